// File: rtl/wide_add_seq_pkg.sv
// Shared types and constants for the wide add sequencer.
// Word width, FSM encoding and fa16 latency live here.
package wide_add_pkg;

   localparam int WORD_W = 16;
   localparam int FA_LAT = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      PIPE  = 3'd2,
      CAPT  = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/result handshake plus the fa16 operand/sum lanes.
// The slave side is the sequencer, the master side its environment.
interface wide_add_seq_if #(
   parameter int NWORDS = 4
);

   localparam int W = wide_add_pkg::WORD_W * NWORDS;

   logic          IN_VALID;
   logic          IN_READY;
   logic [W-1:0]  OPA;
   logic [W-1:0]  OPB;
   logic          CI;
   logic [15:0]   ADD_A;
   logic [15:0]   ADD_B;
   logic          ADD_CIN;
   logic [15:0]   ADD_S;
   logic          ADD_COUT;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [W-1:0]  SUM;
   logic          CO;
   logic          OVF;

   modport slave (
      input  IN_VALID, OPA, OPB, CI,
      input  ADD_S, ADD_COUT, OUT_READY,
      output IN_READY, ADD_A, ADD_B, ADD_CIN,
      output OUT_VALID, SUM, CO, OVF
   );

   modport master (
      output IN_VALID, OPA, OPB, CI,
      output ADD_S, ADD_COUT, OUT_READY,
      input  IN_READY, ADD_A, ADD_B, ADD_CIN,
      input  OUT_VALID, SUM, CO, OVF
   );

endinterface

// File: rtl/wide_add_seq.sv
// Slices a wide add into 16-bit words for an external registered
// fa16, rippling its carry word by word, LSW first.
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int NWORDS = 4
) (
   input  logic           CLK,
   input  logic           RSTN,
   wide_add_seq_if.slave  bus
);

   localparam int W  = WORD_W * NWORDS;
   localparam int IW = 3;
   localparam int PW = 2;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic [W-1:0]    opa_q, opa_d;
   logic [W-1:0]    opb_q, opb_d;
   logic            ci_q, ci_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            co_q, co_d;
   logic            ovf_q, ovf_d;
   logic            out_valid_q, out_valid_d;
   logic [15:0]     add_a, add_b;

   always_comb begin
      add_a = '0;
      add_b = '0;
      for (int i = 0; i < NWORDS; i++) begin
         if (idx_q == IW'(i)) begin
            add_a = opa_q[i*WORD_W +: WORD_W];
            add_b = opb_q[i*WORD_W +: WORD_W];
         end
      end
   end

   assign bus.ADD_A     = add_a;
   assign bus.ADD_B     = add_b;
   assign bus.ADD_CIN   = (idx_q == '0) ? ci_q : carry_q;
   assign bus.IN_READY  = (state_q == IDLE);
   assign bus.OUT_VALID = out_valid_q;
   assign bus.SUM       = sum_q;
   assign bus.CO        = co_q;
   assign bus.OVF       = ovf_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pcnt_d      = pcnt_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      ci_d        = ci_q;
      carry_d     = carry_q;
      sum_d       = sum_q;
      co_d        = co_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (bus.IN_VALID) begin
               opa_d   = bus.OPA;
               opb_d   = bus.OPB;
               ci_d    = bus.CI;
               idx_d   = '0;
               sum_d   = '0;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            pcnt_d  = '0;
            state_d = PIPE;
         end
         // PIPE spans the fa16 stages after its input register
         PIPE: begin
            if (pcnt_q == PW'(FA_LAT - 2)) begin
               state_d = CAPT;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         CAPT: begin
            for (int i = 0; i < NWORDS; i++) begin
               if (idx_q == IW'(i)) begin
                  sum_d[i*WORD_W +: WORD_W] = bus.ADD_S;
               end
            end
            carry_d = bus.ADD_COUT;
            if (idx_q == IW'(NWORDS - 1)) begin
               co_d        = bus.ADD_COUT;
               ovf_d       = (opa_q[W-1] == opb_q[W-1]) &&
                             (bus.ADD_S[15] != opa_q[W-1]);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = DRIVE;
            end
         end
         DONE: begin
            if (bus.OUT_READY) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         pcnt_q      <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         ci_q        <= 1'b0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pcnt_q      <= pcnt_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         ci_q        <= ci_d;
         carry_q     <= carry_d;
         sum_q       <= sum_d;
         co_q        <= co_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq with a behavioural two-register fa16.
// Covers NWORDS=4 vectors, backpressure, mid-op reset and NWORDS=1.
module tb_wide_add_seq;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        ci;
      logic [63:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   nrun = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   wide_add_seq_if #(.NWORDS(4)) b4 ();
   wide_add_seq_if #(.NWORDS(1)) b1 ();

   wide_add_seq #(.NWORDS(4)) u4 (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (b4)
   );

   wide_add_seq #(.NWORDS(1)) u1 (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (b1)
   );

   // fa16 models: input register then sum register, no reset
   logic [15:0] fa4_a, fa4_b, fa4_s;
   logic        fa4_c, fa4_co;
   logic [15:0] fa1_a, fa1_b, fa1_s;
   logic        fa1_c, fa1_co;

   always @(posedge clk) begin
      fa4_a <= b4.ADD_A;
      fa4_b <= b4.ADD_B;
      fa4_c <= b4.ADD_CIN;
      {fa4_co, fa4_s} <= {1'b0, fa4_a} + {1'b0, fa4_b} +
                         {16'd0, fa4_c};
      fa1_a <= b1.ADD_A;
      fa1_b <= b1.ADD_B;
      fa1_c <= b1.ADD_CIN;
      {fa1_co, fa1_s} <= {1'b0, fa1_a} + {1'b0, fa1_b} +
                         {16'd0, fa1_c};
   end

   assign b4.ADD_S    = fa4_s;
   assign b4.ADD_COUT = fa4_co;
   assign b1.ADD_S    = fa1_s;
   assign b1.ADD_COUT = fa1_co;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nrun++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic send4(input logic [63:0] a, input logic [63:0] b,
                        input logic ci);
      int n = 0;
      @(negedge clk);
      b4.OPA = a;
      b4.OPB = b;
      b4.CI = ci;
      b4.IN_VALID = 1'b1;
      while (!b4.IN_READY && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 64'(n < 100), 64'd1);
      @(posedge clk);
      #1 b4.IN_VALID = 1'b0;
   endtask

   task automatic wait4(input bit cin1, output int lat);
      lat = 0;
      if (cin1) chk("cin_ripple", 64'(b4.ADD_CIN), 64'd1);
      do begin
         @(posedge clk);
         lat++;
         #1;
         if (cin1 && !b4.OUT_VALID)
            chk("cin_ripple", 64'(b4.ADD_CIN), 64'd1);
      end while (!b4.OUT_VALID && lat < 100);
   endtask

   task automatic take4(input logic [63:0] s, input logic co,
                        input logic ov);
      chk("sum", b4.SUM, s);
      chk("co", 64'(b4.CO), 64'(co));
      chk("ovf", 64'(b4.OVF), 64'(ov));
      @(negedge clk);
      b4.OUT_READY = 1'b1;
      @(posedge clk);
      #1 b4.OUT_READY = 1'b0;
      chk("valid_drop", 64'(b4.OUT_VALID), 64'd0);
      chk("ready_back", 64'(b4.IN_READY), 64'd1);
   endtask

   vec_t vecs[6];
   int   lat;

   initial begin
      vecs[0] = '{64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                  64'h0, 1'b1, 1'b0};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[3] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[4] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001,
                  1'b1, 64'h0001_0000_0001_0001, 1'b0, 1'b0};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                  1'b0, 64'h0, 1'b1, 1'b1};

      b4.IN_VALID = 1'b0;
      b4.OPA = '0;
      b4.OPB = '0;
      b4.CI = 1'b0;
      b4.OUT_READY = 1'b0;
      b1.IN_VALID = 1'b0;
      b1.OPA = '0;
      b1.OPB = '0;
      b1.CI = 1'b0;
      b1.OUT_READY = 1'b0;

      #12;
      chk("rst_in_ready", 64'(b4.IN_READY), 64'd1);
      chk("rst_out_valid", 64'(b4.OUT_VALID), 64'd0);
      chk("rst_sum", b4.SUM, 64'd0);
      chk("rst_co", 64'(b4.CO), 64'd0);
      chk("rst_ovf", 64'(b4.OVF), 64'd0);
      chk("rst_add_a", 64'(b4.ADD_A), 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 6; i++) begin
         send4(vecs[i].a, vecs[i].b, vecs[i].ci);
         wait4(i == 1, lat);
         chk("latency", 64'(lat), 64'd12);
         take4(vecs[i].s, vecs[i].co, vecs[i].ov);
      end

      // reset lands in the PIPE cycle of word 2
      send4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
      repeat (7) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_sum", b4.SUM, 64'd0);
      chk("mid_rst_in_ready", 64'(b4.IN_READY), 64'd1);
      chk("mid_rst_valid", 64'(b4.OUT_VALID), 64'd0);
      chk("mid_rst_co", 64'(b4.CO), 64'd0);
      chk("mid_rst_ovf", 64'(b4.OVF), 64'd0);
      chk("mid_rst_add_a", 64'(b4.ADD_A), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      send4(64'h1234, 64'h1111, 1'b0);
      wait4(1'b0, lat);
      chk("post_rst_lat", 64'(lat), 64'd12);
      take4(64'h2345, 1'b0, 1'b0);

      // backpressure with a request held during DONE
      send4(64'h1, 64'h2, 1'b0);
      wait4(1'b0, lat);
      chk("bp_lat", 64'(lat), 64'd12);
      @(negedge clk);
      b4.OPA = 64'h5;
      b4.OPB = 64'h6;
      b4.CI = 1'b1;
      b4.IN_VALID = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_sum", b4.SUM, 64'h3);
         chk("bp_co", 64'(b4.CO), 64'd0);
         chk("bp_ovf", 64'(b4.OVF), 64'd0);
         chk("bp_in_ready", 64'(b4.IN_READY), 64'd0);
         chk("bp_valid", 64'(b4.OUT_VALID), 64'd1);
         @(negedge clk);
      end
      b4.OUT_READY = 1'b1;
      @(posedge clk);
      #1 b4.OUT_READY = 1'b0;
      chk("bp_valid_drop", 64'(b4.OUT_VALID), 64'd0);
      chk("bp_idle_ready", 64'(b4.IN_READY), 64'd1);
      @(posedge clk);
      #1 b4.IN_VALID = 1'b0;
      chk("bp_accepted", 64'(b4.IN_READY), 64'd0);
      wait4(1'b0, lat);
      chk("bp2_lat", 64'(lat), 64'd12);
      take4(64'hC, 1'b0, 1'b0);

      // single-word instance
      @(negedge clk);
      b1.OPA = 16'h8000;
      b1.OPB = 16'h8000;
      b1.CI = 1'b0;
      b1.IN_VALID = 1'b1;
      chk("n1_ready", 64'(b1.IN_READY), 64'd1);
      @(posedge clk);
      #1 b1.IN_VALID = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!b1.OUT_VALID && lat < 100);
      chk("n1_lat", 64'(lat), 64'd3);
      chk("n1_sum", 64'(b1.SUM), 64'd0);
      chk("n1_co", 64'(b1.CO), 64'd1);
      chk("n1_ovf", 64'(b1.OVF), 64'd1);
      @(negedge clk);
      b1.OUT_READY = 1'b1;
      @(posedge clk);
      #1 b1.OUT_READY = 1'b0;
      chk("n1_valid_drop", 64'(b1.OUT_VALID), 64'd0);

      $display("[TB] %0d tests run, %0d failed", nrun, nfail);
      $finish;
   end

endmodule
